// File: rtl/prim_pipe_reg.sv
// rtl/prim_pipe_reg.sv - valid/ready pipeline register chain with bubble collapse; PRIM_PIPE_REG_OCC_EN enables occ_o counter
module prim_pipe_reg #(
    parameter int                 Width      = 32,
    parameter int                 Depth      = 2,
    parameter logic [Width-1:0]   ResetValue = '0,
    localparam int                OccW       = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [Width-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] out_data_o,
    output logic [OccW-1:0]  occ_o
);

    logic [Depth-1:0] v;
    logic [Width-1:0] d [Depth];
    logic [Depth:0]   rdy;
    logic [Depth-1:0] up_v;
    logic [Width-1:0] up_d [Depth];

    // A stage may load when it is empty or everything downstream of it moves.
    always_comb begin
        logic r;
        r = out_ready_i;
        rdy = '0;
        rdy[Depth] = out_ready_i;
        for (int k = Depth - 1; k >= 0; k--) begin
            r = !v[k] || r;
            rdy[k] = r;
        end
    end

    always_comb begin
        up_v[0] = in_valid_i;
        up_d[0] = in_data_i;
        for (int k = 1; k < Depth; k++) begin
            up_v[k] = v[k-1];
            up_d[k] = d[k-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v <= '0;
            for (int k = 0; k < Depth; k++) begin
                d[k] <= ResetValue;
            end
        end else if (flush_i) begin
            v <= '0;
        end else begin
            for (int k = 0; k < Depth; k++) begin
                if (rdy[k]) begin
                    v[k] <= up_v[k];
                    if (up_v[k]) begin
                        d[k] <= up_d[k];
                    end
                end
            end
        end
    end

    assign in_ready_o  = rdy[0] && !flush_i;
    assign out_valid_o = v[Depth-1] && !flush_i;
    assign out_data_o  = d[Depth-1];

`ifdef PRIM_PIPE_REG_OCC_EN
    logic            in_xfer;
    logic            out_xfer;
    logic [OccW-1:0] occ_q;

    assign in_xfer  = in_valid_i && in_ready_o;
    assign out_xfer = out_valid_o && out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            occ_q <= '0;
        end else if (in_xfer && !out_xfer) begin
            occ_q <= occ_q + OccW'(1);
        end else if (!in_xfer && out_xfer) begin
            occ_q <= occ_q - OccW'(1);
        end
    end

    assign occ_o = occ_q;
`else
    assign occ_o = '0;
`endif

endmodule

// File: tb/tb_prim_pipe_reg.sv
// tb/tb_prim_pipe_reg.sv - randomized bench for prim_pipe_reg against a slot-position queue model
module tb_prim_pipe_reg;

    localparam int W = 8;
    localparam int D = 3;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic         flush_i = 1'b0;
    logic         in_valid_i = 1'b0;
    logic         in_ready_o;
    logic [W-1:0] in_data_i = '0;
    logic         out_valid_o;
    logic         out_ready_i = 1'b1;
    logic [W-1:0] out_data_o;
    logic [1:0]   occ_o;

    prim_pipe_reg #(.Width(W), .Depth(D), .ResetValue(8'h00)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .in_data_i  (in_data_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_data_o (out_data_o),
        .occ_o      (occ_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        int           pos;
    } ent_t;

    ent_t         q[$];
    logic [W-1:0] last_out = 8'h00;
    int           n_checks = 0;
    int           n_fail = 0;
    bit           chk_en = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Entries occupy slot positions 0..D-1; an entry advances one slot when the
    // slot ahead is free after the entry ahead has moved.
    task automatic step(input bit rst, input bit fl, input bit iv, input logic [W-1:0] dat, input bit ordy);
        bit   exp_ov, exp_ir, popped;
        int   limit, np;
        int   npos[$];
        ent_t nq[$];
        logic [W-1:0] nlast;

        @(negedge clk);
        rst_i = rst; flush_i = fl; in_valid_i = iv; in_data_i = dat; out_ready_i = ordy;
        #1;

        exp_ov = !fl && q.size() > 0 && q[0].pos == D - 1;
        popped = exp_ov && ordy;
        limit = D;
        nlast = last_out;
        for (int i = 0; i < q.size(); i++) begin
            if (i == 0 && popped) begin
                npos.push_back(-1);
            end else begin
                np = (q[i].pos + 1 < limit) ? q[i].pos + 1 : q[i].pos;
                npos.push_back(np);
                limit = np;
                if (np == D - 1 && q[i].pos != D - 1) nlast = q[i].data;
            end
        end
        exp_ir = !fl && limit > 0;

        if (chk_en) begin
            check_eq("out_valid", out_valid_o, exp_ov);
            check_eq("out_data", out_data_o, last_out);
            check_eq("in_ready", in_ready_o, exp_ir);
`ifdef PRIM_PIPE_REG_OCC_EN
            check_eq("occ", occ_o, q.size());
`else
            check_eq("occ", occ_o, 0);
`endif
        end

        @(posedge clk);
        if (rst) begin
            q.delete();
            last_out = 8'h00;
        end else if (fl) begin
            q.delete();
        end else begin
            for (int i = 0; i < q.size(); i++) begin
                if (npos[i] >= 0) nq.push_back('{data: q[i].data, pos: npos[i]});
            end
            if (iv && exp_ir) nq.push_back('{data: dat, pos: 0});
            q = nq;
            last_out = nlast;
        end
    endtask

    initial begin
        step(1, 0, 0, 8'h00, 1);
        chk_en = 1'b1;
        step(1, 0, 0, 8'h00, 1);

        step(0, 0, 1, 8'hA5, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 8'($urandom), 1);

        for (int i = 1; i <= 16; i++) step(0, 0, 1, 8'(i), 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 8'($urandom), 1);

        for (int i = 8'h11; i <= 8'h14; i++) step(0, 0, 1, 8'(i), 0);
        step(0, 0, 1, 8'h14, 0);
        step(0, 0, 1, 8'h14, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 8'($urandom), 1);

        for (int i = 8'h21; i <= 8'h23; i++) step(0, 0, 1, 8'(i), 0);
        step(0, 0, 0, 8'h00, 0);
        step(0, 0, 1, 8'h55, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 8'($urandom), 1);

        step(0, 0, 1, 8'h31, 0);
        step(0, 0, 1, 8'h32, 0);
        step(0, 1, 1, 8'h33, 1);
        step(0, 0, 0, 8'h00, 1);
        step(0, 0, 0, 8'h00, 1);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 1) == 1);
        end

        step(1, 1, 1, 8'hFF, 0);
        step(1, 0, 1, 8'hFF, 0);
        step(0, 0, 0, 8'h00, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
